// File: rtl/mod_check_arbiter.sv
// Round-robin arbiter that time-shares one mod_checker among NREQ requesters,
// with a watchdog that resets the checker when its done never arrives.
module mod_check_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*IDX_W-1:0] req_index,
    output logic [NREQ-1:0]       ack,
    output logic [IDX_W-1:0]      ack_index,
    output logic                  ack_err,
    output logic                  busy,
    output logic                  chk_en,
    output logic [IDX_W-1:0]      chk_index,
    output logic                  chk_rst,
    input  logic                  chk_done,
    input  logic [IDX_W-1:0]      chk_index_out
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_q, last_d;
    logic [7:0]        timer_q, timer_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [IDX_W-1:0]  ack_index_q, ack_index_d;
    logic              ack_err_q, ack_err_d;
    logic              busy_q, busy_d;
    logic              chk_en_q, chk_en_d;
    logic [IDX_W-1:0]  chk_index_q, chk_index_d;
    logic              chk_rst_q, chk_rst_d;

    logic              win_found;
    logic [GW-1:0]     win_idx;
    logic [GW-1:0]     cand;
    logic [NREQ-1:0]   grant_oh;

    assign grant_oh = NREQ'(1) << grant_q;

    // Search upward from the requester after the last one served, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_q) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // NOTE: every *_d gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        timer_d     = timer_q;
        ack_d       = '0;
        ack_index_d = ack_index_q;
        ack_err_d   = 1'b0;
        chk_en_d    = 1'b0;
        chk_index_d = chk_index_q;
        chk_rst_d   = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d     = win_idx;
                    chk_index_d = req_index[int'(win_idx)*IDX_W +: IDX_W];
                    chk_en_d    = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 8'd1;
                // A done arriving on the last allowed cycle beats the watchdog.
                if (chk_done) begin
                    ack_d       = grant_oh;
                    ack_index_d = chk_index_out;
                    state_d     = S_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    ack_d       = grant_oh;
                    ack_index_d = '0;
                    ack_err_d   = 1'b1;
                    chk_rst_d   = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state flops use non-blocking assignments so all of them see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            last_q      <= GW'(NREQ - 1);
            timer_q     <= '0;
            ack_q       <= '0;
            ack_index_q <= '0;
            ack_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            chk_en_q    <= 1'b0;
            chk_index_q <= '0;
            chk_rst_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            timer_q     <= timer_d;
            ack_q       <= ack_d;
            ack_index_q <= ack_index_d;
            ack_err_q   <= ack_err_d;
            busy_q      <= busy_d;
            chk_en_q    <= chk_en_d;
            chk_index_q <= chk_index_d;
            chk_rst_q   <= chk_rst_d;
        end
    end

    assign ack       = ack_q;
    assign ack_index = ack_index_q;
    assign ack_err   = ack_err_q;
    assign busy      = busy_q;
    assign chk_en    = chk_en_q;
    assign chk_index = chk_index_q;
    assign chk_rst   = chk_rst_q;

endmodule

// File: tb/tb_mod_check_arbiter.sv
// Bench for mod_check_arbiter: a behavioural checker model, directed vectors,
// hand-written corner sequences and a randomized run against a transaction-level model.
module tb_mod_check_arbiter;

    localparam int NREQ    = 4;
    localparam int IDX_W   = 3;
    localparam int TIMEOUT = 15;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*IDX_W-1:0] req_index = '0;
    logic [NREQ-1:0]       ack;
    logic [IDX_W-1:0]      ack_index;
    logic                  ack_err;
    logic                  busy;
    logic                  chk_en;
    logic [IDX_W-1:0]      chk_index;
    logic                  chk_rst;
    logic                  chk_done;
    logic [IDX_W-1:0]      chk_index_out;

    mod_check_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_index     (req_index),
        .ack           (ack),
        .ack_index     (ack_index),
        .ack_err       (ack_err),
        .busy          (busy),
        .chk_en        (chk_en),
        .chk_index     (chk_index),
        .chk_rst       (chk_rst),
        .chk_done      (chk_done),
        .chk_index_out (chk_index_out)
    );

    always #5 clk = ~clk;

    // Checker model: done pulses lat cycles after en is sampled, result is index ^ mask;
    // lat of 0 means it never answers. ovr_* lets a sequence force done by hand.
    int               chk_lat  = 4;
    logic [IDX_W-1:0] chk_mask = '0;
    logic             ovr_done = 1'b0;
    logic [IDX_W-1:0] ovr_idx  = '0;
    int               m_cnt    = 0;
    logic             m_done   = 1'b0;
    logic [IDX_W-1:0] m_cap    = '0;
    logic [IDX_W-1:0] m_res    = '0;

    always @(posedge clk) begin
        if (!chk_rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (chk_en) begin
                m_cnt <= chk_lat;
                m_cap <= chk_index ^ chk_mask;
            end else if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_res  <= m_cap;
                m_cnt  <= 0;
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign chk_done      = m_done | ovr_done;
    assign chk_index_out = ovr_done ? ovr_idx : m_res;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [NREQ-1:0]       req;
        logic [NREQ*IDX_W-1:0] idx;
        int                    lat;
        logic [IDX_W-1:0]      mask;
        logic [NREQ-1:0]       exp_ack;
        logic [IDX_W-1:0]      exp_idx;
        logic                  exp_err;
        int                    exp_lat;
        logic [IDX_W-1:0]      exp_chk_idx;
    } vec_t;

    vec_t vecs[10];

    task automatic do_reset();
        req      = '0;
        ovr_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {ack, ack_index, ack_err, busy, chk_en, chk_index, chk_rst}, 0);
        rst = 1'b1;
        @(negedge clk);
        check("chk_rst_release", chk_rst, 1);
    endtask

    task automatic run_txn(input vec_t t, input string tag);
        int               cycles, en_cnt, rst_low, idx_bad;
        logic             got;
        logic [NREQ-1:0]  a_v;
        logic [IDX_W-1:0] i_v;
        logic             e_v;
        chk_lat  = t.lat;
        chk_mask = t.mask;
        @(negedge clk);
        req       = t.req;
        req_index = t.idx;
        cycles = 0; en_cnt = 0; rst_low = 0; idx_bad = 0;
        got = 1'b0; a_v = '0; i_v = '0; e_v = 1'b0;
        while (!got && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (chk_en) en_cnt++;
            if (!chk_rst) rst_low++;
            if (busy && chk_index !== t.exp_chk_idx) idx_bad++;
            if (ack != 0) begin
                got = 1'b1;
                a_v = ack;
                i_v = ack_index;
                e_v = ack_err;
            end
        end
        req = '0;
        check({tag, "_ack_seen"}, got, 1);
        check({tag, "_ack"}, a_v, t.exp_ack);
        check({tag, "_ack_index"}, i_v, t.exp_idx);
        check({tag, "_ack_err"}, e_v, t.exp_err);
        check({tag, "_latency"}, cycles - 1, t.exp_lat);
        check({tag, "_chk_en_pulses"}, en_cnt, 1);
        check({tag, "_chk_rst_low_cycles"}, rst_low, t.exp_err ? 1 : 0);
        check({tag, "_chk_index_unstable"}, idx_bad, 0);
        @(negedge clk);
        check({tag, "_idle_after"}, {ack, busy}, 0);
    endtask

    logic [NREQ-1:0]  seen_ack[8];
    logic [IDX_W-1:0] seen_idx[8];
    int               seen_t[8];
    int               seen_n;

    task automatic collect(input int n, input int budget);
        seen_n = 0;
        for (int c = 1; c <= budget && seen_n < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack != 0) begin
                seen_ack[seen_n] = ack;
                seen_idx[seen_n] = ack_index;
                seen_t[seen_n]   = c;
                seen_n++;
            end
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return 0;
    endfunction

    // Transaction-level reference: the arbiter is free again two edges after an ack,
    // and an ack lands lat+2 edges after the grant, or TIMEOUT+1 edges if the checker is too slow.
    task automatic run_random();
        int               lats[6];
        logic [IDX_W-1:0] masks[6];
        int               e, free_e, last, g, a, id;
        logic [IDX_W-1:0] t_idx, t_res;
        logic             t_err, in_tx, drain;
        logic [NREQ-1:0]  exp_ack;
        lats  = '{4, 2, 20, 14, 15, 1};
        masks = '{3'd0, 3'd5, 3'd0, 3'd3, 3'd6, 3'd7};
        e = 0; free_e = 0; last = NREQ - 1; g = -100; a = -100; id = 0;
        t_idx = '0; t_res = '0; t_err = 1'b0;
        for (int b = 0; b < 6; b++) begin
            chk_lat  = lats[b];
            chk_mask = masks[b];
            for (int c = 0; c < 400; c++) begin
                drain = (c >= 250);
                if (drain && req == 0 && e > a) break;
                @(posedge clk);
                e++;
                if (e >= free_e && req != 0) begin
                    id    = rr_pick(req, last);
                    t_idx = req_index[id*IDX_W +: IDX_W];
                    g     = e;
                    if (chk_lat != 0 && chk_lat <= TIMEOUT - 1) begin
                        a     = e + chk_lat + 2;
                        t_err = 1'b0;
                        t_res = t_idx ^ chk_mask;
                    end else begin
                        a     = e + TIMEOUT + 1;
                        t_err = 1'b1;
                        t_res = '0;
                    end
                    free_e = a + 2;
                    last   = id;
                end
                @(negedge clk);
                in_tx   = (e >= g && e <= a);
                exp_ack = (e == a) ? (NREQ'(1) << id) : '0;
                check("rnd_ack", ack, exp_ack);
                if (e == a) check("rnd_ack_index", ack_index, t_res);
                check("rnd_ack_err", ack_err, (e == a) && t_err);
                check("rnd_busy", busy, in_tx);
                check("rnd_chk_en", chk_en, e == g);
                check("rnd_chk_rst", chk_rst, !((e == a) && t_err));
                if (in_tx) check("rnd_chk_index", chk_index, t_idx);
                for (int i = 0; i < NREQ; i++) begin
                    if (in_tx && i == id && e < a) begin
                        if ($urandom_range(7) == 0) req[i] = 1'b0;
                        req_index[i*IDX_W +: IDX_W] = IDX_W'($urandom);
                    end else if (e == a && i == id) begin
                        req[i] = !drain && ($urandom_range(1) == 1);
                        req_index[i*IDX_W +: IDX_W] = IDX_W'($urandom);
                    end else if (!req[i] && !drain && !(in_tx && i == id)) begin
                        if ($urandom_range(3) == 0) begin
                            req[i] = 1'b1;
                            req_index[i*IDX_W +: IDX_W] = IDX_W'($urandom);
                        end
                    end
                end
            end
        end
        req = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int ack_cnt, busy_cnt, early;

        // req, indices {i3,i2,i1,i0}, lat, mask, ack, ack_index, err, latency, chk_index
        vecs[0] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd5}, 4,  3'd0, 4'b0001, 3'd5, 1'b0, 6,  3'd5};
        vecs[1] = '{4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 4,  3'd0, 4'b0010, 3'd2, 1'b0, 6,  3'd2};
        vecs[2] = '{4'b1001, {3'd6, 3'd0, 3'd0, 3'd7}, 4,  3'd3, 4'b1000, 3'd5, 1'b0, 6,  3'd6};
        vecs[3] = '{4'b1001, {3'd6, 3'd0, 3'd0, 3'd7}, 4,  3'd0, 4'b0001, 3'd7, 1'b0, 6,  3'd7};
        vecs[4] = '{4'b0010, {3'd0, 3'd0, 3'd6, 3'd0}, 0,  3'd0, 4'b0010, 3'd0, 1'b1, 16, 3'd6};
        vecs[5] = '{4'b0110, {3'd0, 3'd6, 3'd3, 3'd0}, 4,  3'd7, 4'b0100, 3'd1, 1'b0, 6,  3'd6};
        vecs[6] = '{4'b0011, {3'd0, 3'd0, 3'd2, 3'd4}, 2,  3'd0, 4'b0001, 3'd4, 1'b0, 4,  3'd4};
        vecs[7] = '{4'b1100, {3'd5, 3'd3, 3'd0, 3'd0}, 1,  3'd0, 4'b0100, 3'd3, 1'b0, 3,  3'd3};
        vecs[8] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, 14, 3'd1, 4'b0001, 3'd3, 1'b0, 16, 3'd2};
        vecs[9] = '{4'b0011, {3'd0, 3'd0, 3'd1, 3'd2}, 15, 3'd0, 4'b0010, 3'd0, 1'b1, 16, 3'd1};

        do_reset();
        for (int v = 0; v < 10; v++) run_txn(vecs[v], $sformatf("vec%0d", v));

        // All four requesters held high: strict rotation, one ack every 8 cycles.
        do_reset();
        chk_lat = 4; chk_mask = '0;
        @(negedge clk);
        req = 4'b1111;
        req_index = {3'd4, 3'd3, 3'd2, 3'd1};
        collect(5, 60);
        req = '0;
        check("rr_count", seen_n, 5);
        for (int k = 0; k < seen_n; k++) begin
            check($sformatf("rr_ack%0d", k), seen_ack[k], NREQ'(1) << (k % NREQ));
            check($sformatf("rr_idx%0d", k), seen_idx[k], (k % NREQ) + 1);
            if (k > 0) check($sformatf("rr_gap%0d", k), seen_t[k] - seen_t[k-1], 8);
            else check("rr_first_latency", seen_t[0] - 1, 6);
        end
        repeat (2) @(negedge clk);
        check("rr_idle_after", busy, 0);

        // Two requesters held high alternate.
        do_reset();
        @(negedge clk);
        req = 4'b0101;
        req_index = {3'd0, 3'd6, 3'd0, 3'd2};
        collect(4, 50);
        req = '0;
        check("fair_count", seen_n, 4);
        for (int k = 0; k < seen_n; k++) begin
            check($sformatf("fair_ack%0d", k), seen_ack[k], (k % 2 == 0) ? 4'b0001 : 4'b0100);
            check($sformatf("fair_idx%0d", k), seen_idx[k], (k % 2 == 0) ? 2 : 6);
        end
        repeat (2) @(negedge clk);

        // Asynchronous reset while the checker is running.
        @(negedge clk);
        req = 4'b0001;
        req_index = {3'd0, 3'd0, 3'd0, 3'd3};
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("async_busy_before", busy, 1);
        #2 rst = 1'b0;
        #1 check("async_reset_outputs", {ack, ack_index, ack_err, busy, chk_en, chk_index, chk_rst}, 0);
        req = '0;
        ack_cnt = 0;
        repeat (3) @(negedge clk) if (ack != 0) ack_cnt++;
        rst = 1'b1;
        repeat (8) @(negedge clk) if (ack != 0) ack_cnt++;
        check("async_no_ack", ack_cnt, 0);
        check("async_chk_rst_back", chk_rst, 1);
        run_txn('{4'b0100, {3'd0, 3'd7, 3'd0, 3'd0}, 4, 3'd0, 4'b0100, 3'd7, 1'b0, 6, 3'd7}, "post_reset");

        // done pulsed while idle must be ignored.
        @(negedge clk);
        ovr_idx  = 3'd5;
        ovr_done = 1'b1;
        @(negedge clk);
        ovr_done = 1'b0;
        ack_cnt = 0; busy_cnt = 0;
        repeat (6) @(negedge clk) begin
            if (ack != 0) ack_cnt++;
            if (busy) busy_cnt++;
        end
        check("spurious_no_ack", ack_cnt, 0);
        check("spurious_no_busy", busy_cnt, 0);

        // done arriving on the very cycle the watchdog would fire.
        chk_lat = 0;
        @(negedge clk);
        req = 4'b0001;
        req_index = {3'd0, 3'd0, 3'd0, 3'd2};
        early = 0;
        repeat (TIMEOUT + 1) begin
            @(posedge clk);
            @(negedge clk);
            if (ack != 0) early++;
        end
        ovr_idx  = 3'd6;
        ovr_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("coinc_no_early_ack", early, 0);
        check("coinc_ack", ack, 4'b0001);
        check("coinc_ack_index", ack_index, 6);
        check("coinc_ack_err", ack_err, 0);
        check("coinc_chk_rst", chk_rst, 1);
        ovr_done = 1'b0;
        req = '0;
        @(negedge clk);
        check("coinc_idle_after", busy, 0);

        do_reset();
        run_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mod_check_arbiter.md
# mod_check_arbiter

Shares one `mod_checker` instance among NREQ requesters. Accepts indexed check requests, grants one at a time in round-robin order, and drives a one-cycle start pulse into the checker. It holds the checker's index input stable until the checker reports `done`, then returns the checker's `index_out` to the granted requester with a one-cycle acknowledge. A watchdog recovers the checker if `done` never arrives.

## Interface
- `NREQ`, 4: number of requesters; 2 to 8 supported.
- `IDX_W`, 3: index width; matches the checker's `index_in`/`index_out`.
- `TIMEOUT`, 15: cycles allowed in WAIT before abort; range 1 to 255.
- `clk`  in  1  single clock; all registers update on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request level.
- `req_index`  in  NREQ*IDX_W  requester i's index is bits [i*IDX_W +: IDX_W].
- `ack`  out  NREQ  one-hot, one-cycle completion pulse to the granted requester.
- `ack_index`  out  IDX_W  result index; valid while any `ack` bit is high.
- `ack_err`  out  1  high with `ack` when the transaction timed out.
- `busy`  out  1  high in every state except IDLE.
- `chk_en`  out  1  to checker `en`; one-cycle start pulse.
- `chk_index`  out  IDX_W  to checker `index_in`; held for the whole transaction.
- `chk_rst`  out  1  to checker `rst` (checker's reset is synchronous active-low).
- `chk_done`  in  1  from checker `done`.
- `chk_index_out`  in  IDX_W  from checker `index_out`.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. The state register and all outputs are registered.
- IDLE, with `req` != 0:
  - Select the first set bit of `req`, searching upward from `last+1` modulo NREQ.
  - Latch the winner into `grant` and its `req_index` slice into `chk_index`.
  - Go to ISSUE.
- ISSUE: `chk_en`=1 for exactly this cycle. Clear the timer. Go to WAIT.
- WAIT: the timer increments each cycle.
  - If `chk_done`=1: register `chk_index_out` into `ack_index`, set err=0, go to RESP.
  - Else, if the timer equals TIMEOUT-1: set `ack_index`=0, err=1, drive `chk_rst`=0 for one cycle, go to RESP.
  - If `chk_done` and the timeout coincide, `chk_done` wins.
- RESP:
  - `ack[grant]`=1, and `ack_err`=err.
  - Set `last`=`grant`. Go to IDLE.
- `chk_done` is ignored outside WAIT.
- `chk_en` is never high in two consecutive cycles. This prevents the checker re-arming while it sits in its Init state.
- Requester rules:
  - Hold `req` and `req_index` stable until `ack`.
  - `req` may stay high across `ack` to queue the next request.
  - If `req` drops mid-transaction, the transaction still completes and `ack` still pulses.
  - A `req_index` change after grant has no effect.
- Reset values:
  - state=IDLE, `last`=NREQ-1, so requester 0 has first priority.
  - `ack`=0, `ack_index`=0, `ack_err`=0, `busy`=0, `chk_en`=0, `chk_index`=0, timer=0.
  - `chk_rst`=0, then 1 from the first clock edge after `rst` deasserts.
- Asserting `rst` mid-transaction:
  - Abandons the transaction with no `ack`.
  - Drives `chk_rst` low, which resets the checker on its next clock edge.

## Timing
- `req` sampled at edge 0:
  - ISSUE follows edge 0.
  - Checker samples `chk_en` at edge 1.
  - `chk_done` is high after edge 5.
  - RESP follows edge 6, so `ack` is high in the cycle after edge 6.
- Request-to-`ack` latency is 6 cycles (checker latency L=4, plus 2).
- IDLE is re-entered after edge 7. Back-to-back throughput is one transaction per 8 cycles.
- Timeout path: `ack` with `ack_err` arrives at ISSUE + TIMEOUT + 1 cycles.
- `busy` rises the cycle after the grant and falls the cycle after `ack`.

## Test plan
- Reset, then single request:
  - Stimulus: `req`=0001, req0 index=5.
  - Required: `chk_en` pulses once; `chk_index`=5 throughout.
  - Required: `ack`=0001 with `ack_index`=5 and `ack_err`=0, 6 cycles after `req` sampled.
- All four requesters held high, indices 1, 2, 3, 4:
  - Required: acks in order 0, 1, 2, 3, then 0 again, 8 cycles apart.
  - Required: each `ack_index` equals that requester's index.
- Fairness:
  - Stimulus: req0 and req2 both held high continuously.
  - Required: grants alternate 0, 2, 0, 2.
- Timeout:
  - Stimulus: `chk_done` tied 0, TIMEOUT=15, `req`=0010.
  - Required: `chk_rst` low for one cycle; `ack`=0010 with `ack_err`=1 and `ack_index`=0.
  - Required: `busy` returns to 0.
- Async reset mid-transaction:
  - Stimulus: assert `rst` during WAIT.
  - Required: all outputs return to reset values immediately; no `ack`.
  - Required: a new request after reset completes normally.
- Spurious and coincident `chk_done`:
  - Stimulus: `chk_done` pulsed while in IDLE.
  - Required: no `ack`.
  - Stimulus: `chk_done` coinciding with the final timeout cycle.
  - Required: `ack_err`=0 and `ack_index`=`chk_index_out`.
